seq_magnitude_comparator: RTL and testbench

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

---
 rtl/cmp_pkg.sv | 21 ++
 rtl/chunk_comparator.sv | 16 +
 rtl/seq_magnitude_comparator.sv | 127 ++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding, {e,g,l} result encoding and chunk-index sizing.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result vector is packed as {e, g, l}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    function automatic int idx_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/chunk_comparator.sv
// Combinational unsigned comparator for one CHUNK-bit slice of the operands.
module chunk_comparator #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the latched operands MSB chunk first
// through a single chunk comparator and exits on the first differing chunk.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             e,
    output logic             g,
    output logic             l
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = idx_width(NCH);
    localparam logic [IDXW-1:0]  IDX_MSB  = IDXW'(NCH - 1);
    localparam logic [CHUNK-1:0] TOP_MASK = CHUNK'(1) << (CHUNK - 1);

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic              signed_reg, signed_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic [2:0]        res_reg, res_next;

    logic [CHUNK-1:0]  a_chunks [NCH];
    logic [CHUNK-1:0]  b_chunks [NCH];
    logic [CHUNK-1:0]  a_sel, b_sel;
    logic              chunk_eq, chunk_gt, chunk_lt;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so only the MSB chunk needs touching in signed mode.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chunk
            if (gi == NCH - 1) begin : g_msb
                assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK] ^ ({CHUNK{signed_reg}} & TOP_MASK);
                assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK] ^ ({CHUNK{signed_reg}} & TOP_MASK);
            end else begin : g_plain
                assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
                assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
            end
        end
    endgenerate

    assign a_sel = a_chunks[idx_reg];
    assign b_sel = b_chunks[idx_reg];

    chunk_comparator #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .a  (a_sel),
        .b  (b_sel),
        .eq (chunk_eq),
        .gt (chunk_gt),
        .lt (chunk_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            signed_reg <= 1'b0;
            idx_reg    <= '0;
            res_reg    <= RES_NONE;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            signed_reg <= signed_next;
            idx_reg    <= idx_next;
            res_reg    <= res_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        signed_next = signed_reg;
        idx_next    = idx_reg;
        res_next    = res_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next      = A;
                    b_next      = B;
                    signed_next = signed_mode;
                    idx_next    = IDX_MSB;
                    res_next    = RES_NONE;
                    state_next  = CMP;
                end
            end
            CMP: begin
                if (!chunk_eq) begin
                    res_next   = {1'b0, chunk_gt, chunk_lt};
                    state_next = DONE;
                end else if (idx_reg == '0) begin
                    res_next   = RES_EQ;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg == CMP);
    assign done      = (state_reg == DONE);
    assign {e, g, l} = res_reg;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomised, self-checking bench for seq_magnitude_comparator with a 32/8 and
// an 8/1 instance, compared every cycle against a latency/result model.
`timescale 1ns/1ps
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_v [2];
    logic        sm_v [2];
    logic [63:0] a_v  [2];
    logic [63:0] b_v  [2];
    logic [4:0]  obs  [2];
    logic [4:0]  exp_v[2];
    logic        chk_en = 1'b0;

    int errors = 0;
    int checks = 0;

    logic busy0, done0, e0, g0, l0;
    logic busy1, done1, e1, g1, l1;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(st_v[0]), .signed_mode(sm_v[0]),
        .A(a_v[0][31:0]), .B(b_v[0][31:0]),
        .busy(busy0), .done(done0), .e(e0), .g(g0), .l(l0)
    );

    seq_magnitude_comparator #(.WIDTH(8), .CHUNK(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st_v[1]), .signed_mode(sm_v[1]),
        .A(a_v[1][7:0]), .B(b_v[1][7:0]),
        .busy(busy1), .done(done1), .e(e1), .g(g1), .l(l1)
    );

    assign obs[0] = {busy0, done0, e0, g0, l0};
    assign obs[1] = {busy1, done1, e1, g1, l1};

    // Expected {e,g,l} from plain (signed or unsigned) arithmetic on w-bit operands.
    function automatic logic [2:0] ref_res(input int w, input logic sm,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a & mask;
        b = b & mask;
        if (sm) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            return {sa == sb, sa > sb, sa < sb};
        end
        return {a == b, a > b, a < b};
    endfunction

    // Chunks examined = chunks from the top down to the one holding the highest differing bit.
    function automatic int ref_lat(input int w, input int c,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] x;
        x = (a ^ b) & ((w == 64) ? '1 : ((64'd1 << w) - 64'd1));
        for (int i = w - 1; i >= 0; i--)
            if (x[i]) return w / c - i / c;
        return w / c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: on accept, precompute result and latency, then count down.
    for (genvar gi = 0; gi < 2; gi++) begin : g_model
        localparam int MW = (gi == 0) ? 32 : 8;
        localparam int MC = (gi == 0) ? 8 : 1;
        int         phase;
        int         cnt;
        logic [2:0] res;
        logic [2:0] pend;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                phase <= 0;
                cnt   <= 0;
                res   <= 3'b000;
                pend  <= 3'b000;
            end else begin
                case (phase)
                    0: if (st_v[gi]) begin
                        res   <= 3'b000;
                        pend  <= ref_res(MW, sm_v[gi], a_v[gi], b_v[gi]);
                        cnt   <= ref_lat(MW, MC, a_v[gi], b_v[gi]);
                        phase <= 1;
                    end
                    1: if (cnt <= 1) begin
                        res   <= pend;
                        phase <= 2;
                    end else begin
                        cnt <= cnt - 1;
                    end
                    default: phase <= 0;
                endcase
            end
        end
        assign exp_v[gi] = {phase == 1, phase == 2, res};
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++)
                check($sformatf("cycle dut%0d {busy,done,e,g,l}", d), obs[d], exp_v[d]);
        end
    end

    task automatic run_cmp(input int d, input logic [63:0] a, input logic [63:0] b,
                           input logic sm, input bit hold_start,
                           output logic [2:0] res, output int lat, output int nbusy);
        @(negedge clk);
        a_v[d]  = a;
        b_v[d]  = b;
        sm_v[d] = sm;
        st_v[d] = 1'b1;
        @(negedge clk);
        if (!hold_start) st_v[d] = 1'b0;
        a_v[d]  = hold_start ? 64'd0 : {$urandom, $urandom};
        b_v[d]  = hold_start ? b : {$urandom, $urandom};
        sm_v[d] = ~sm;
        lat   = 0;
        nbusy = 0;
        while (!obs[d][3] && lat < 40) begin
            if (obs[d][4]) nbusy++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) begin
            errors++;
            checks++;
            $display("FAIL timeout dut%0d: got no done expected done within 40 cycles", d);
        end
        res = obs[d][2:0];
        $display("txn dut%0d a=%h b=%h signed=%0d egl=%b latency=%0d busy_cycles=%0d",
                 d, a, b, sm, res, lat, nbusy);
    endtask

    logic [2:0] r;
    int         lat, nb;

    initial begin
        for (int d = 0; d < 2; d++) begin
            st_v[d] = 1'b0; sm_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0;
        end

        // Pin the model with hand-worked cases
        check("model eq",        64'(ref_res(32, 1'b0, 64'h12345678, 64'h12345678)), 64'(3'b100));
        check("model signed lt", 64'(ref_res(32, 1'b1, 64'h80000000, 64'h7FFFFFFF)), 64'(3'b001));
        check("model lat msb",   64'(ref_lat(32, 8, 64'h80000000, 64'h7FFFFFFF)), 64'd1);
        check("model lat lsb",   64'(ref_lat(32, 8, 64'hFF, 64'hFE)), 64'd4);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset dut32", 64'(obs[0]), 64'd0);
        check("reset dut8",  64'(obs[1]), 64'd0);
        chk_en = 1'b1;

        run_cmp(0, 64'h12345678, 64'h12345678, 1'b0, 1'b0, r, lat, nb);
        check("equal egl", 64'(r), 64'(3'b100));
        check("equal latency", 64'(lat), 64'd4);
        check("equal busy cycles", 64'(nb), 64'd4);

        run_cmp(0, 64'h80000000, 64'h7FFFFFFF, 1'b0, 1'b0, r, lat, nb);
        check("msb unsigned egl", 64'(r), 64'(3'b010));
        check("msb unsigned latency", 64'(lat), 64'd1);
        run_cmp(0, 64'h80000000, 64'h7FFFFFFF, 1'b1, 1'b0, r, lat, nb);
        check("msb signed egl", 64'(r), 64'(3'b001));
        check("msb signed latency", 64'(lat), 64'd1);

        run_cmp(0, 64'h000000FF, 64'h000000FE, 1'b0, 1'b0, r, lat, nb);
        check("lsb egl", 64'(r), 64'(3'b010));
        check("lsb latency", 64'(lat), 64'd4);

        // start held high while A is zeroed mid-compare
        run_cmp(0, 64'd5, 64'd3, 1'b0, 1'b1, r, lat, nb);
        check("held start egl", 64'(r), 64'(3'b010));
        @(negedge clk);
        check("held start idle gap busy", 64'(busy0), 64'd0);
        @(negedge clk);
        check("held start reaccept busy", 64'(busy0), 64'd1);
        st_v[0] = 1'b0;
        lat = 0;
        while (!done0 && lat < 40) begin @(negedge clk); lat++; end
        check("held start second egl", 64'({e0, g0, l0}), 64'(3'b001));

        // Reset in the second CMP cycle
        @(negedge clk);
        a_v[0] = 64'h12345678; b_v[0] = 64'h12345678; sm_v[0] = 1'b0; st_v[0] = 1'b1;
        @(negedge clk);
        st_v[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset dut32", 64'(obs[0]), 64'd0);
        check("async reset dut8",  64'(obs[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no done after reset", 64'(done0), 64'd0);
        end
        run_cmp(0, 64'd3, 64'd5, 1'b0, 1'b0, r, lat, nb);
        check("post reset egl", 64'(r), 64'(3'b001));
        check("post reset latency", 64'(lat), 64'd4);

        // 8-bit, 1-bit-chunk sweep
        for (int i = 0; i < 16; i++) begin
            run_cmp(1, 64'(i), 64'(15 - i), 1'b0, 1'b0, r, lat, nb);
            check($sformatf("sweep i=%0d egl", i), 64'(r), (i <= 7) ? 64'(3'b001) : 64'(3'b010));
            check($sformatf("sweep i=%0d latency", i), 64'(lat), 64'd5);
        end

        // Randomised traffic on both instances
        for (int n = 0; n < 120; n++) begin
            int          d, w, c, mode;
            logic [63:0] a, b;
            logic        sm;
            d    = $urandom_range(1, 0);
            w    = (d == 0) ? 32 : 8;
            c    = (d == 0) ? 8 : 1;
            mode = $urandom_range(3, 0);
            sm   = 1'($urandom_range(1, 0));
            a    = {$urandom, $urandom};
            case (mode)
                0: b = {$urandom, $urandom};
                1: b = a;
                2: b = a ^ 64'(1 << $urandom_range(c - 1, 0));
                default: b = a ^ (64'd1 << (w - 1));
            endcase
            run_cmp(d, a, b, sm, 1'b0, r, lat, nb);
            check($sformatf("random %0d egl", n), 64'(r), 64'(ref_res(w, sm, a, b)));
            check($sformatf("random %0d latency", n), 64'(lat), 64'(ref_lat(w, c, a, b)));
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
